// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int ADDR_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 0;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Initiator/responder data-memory bus.
interface dmem_responder_if;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;

  modport master (
    output dm_req, dm_addr, dm_wen, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata, dm_err
  );

  modport slave (
    input  dm_req, dm_addr, dm_wen, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata, dm_err
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-enabled synchronous single-port word storage with registered read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  input  logic [3:0]        wen,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen == 4'b0000) begin
        q <= mem[idx];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, optional wait states,
// one-cycle response strobe with read data or an out-of-range error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  dmem_responder_if.slave   bus
);

  localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) != 32'd0;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hold_addr;
  logic [3:0]       hold_wen;
  logic [31:0]      hold_wdata;
  logic             ready_q;
  logic             rvalid_q;
  logic             err_q;
  logic             rd_ok;
  logic [31:0]      arr_q;

  logic             accept;
  logic             enter_resp;
  logic [31:0]      sel_addr;
  logic [3:0]       sel_wen;
  logic [31:0]      sel_wdata;
  logic             sel_oor;
  logic             arr_en;

  // With zero wait states the access commits on the accepting edge, so the
  // storage is fed straight from the bus; otherwise from the holding registers.
  always_comb begin
    accept     = bus.dm_req && ready_q;
    enter_resp = ((state == WAIT) && (cnt == '0)) || (accept && ZERO_WAIT);
    if (state == WAIT) begin
      sel_addr  = hold_addr;
      sel_wen   = hold_wen;
      sel_wdata = hold_wdata;
    end else begin
      sel_addr  = bus.dm_addr;
      sel_wen   = bus.dm_wen;
      sel_wdata = bus.dm_wdata;
    end
    sel_oor = out_of_range(sel_addr);
    arr_en  = enter_resp && !sel_oor && resetn;
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .idx   (sel_addr[ADDR_W+1:2]),
    .wen   (sel_wen),
    .wdata (sel_wdata),
    .q     (arr_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_addr  <= '0;
      hold_wen   <= '0;
      hold_wdata <= '0;
      ready_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_ok      <= 1'b0;
    end else begin
      rvalid_q <= enter_resp;
      err_q    <= enter_resp && sel_oor;
      rd_ok    <= enter_resp && !sel_oor && (sel_wen == 4'b0000);
      if (accept) begin
        hold_addr  <= bus.dm_addr;
        hold_wen   <= bus.dm_wen;
        hold_wdata <= bus.dm_wdata;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (ZERO_WAIT) begin
              state   <= RESP;
              ready_q <= 1'b1;
            end else begin
              state   <= WAIT;
              cnt     <= WAIT_LOAD;
              ready_q <= 1'b0;
            end
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dm_ready  = ready_q;
  assign bus.dm_rvalid = rvalid_q;
  assign bus.dm_err    = err_q;
  assign bus.dm_rdata  = rd_ok ? arr_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with zero, two and three wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2, rst3;

  dmem_responder_if bus0();
  dmem_responder_if bus2();
  dmem_responder_if bus3();

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .resetn(rst0), .bus(bus0.slave));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .resetn(rst2), .bus(bus2.slave));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (.clk(clk), .resetn(rst3), .bus(bus3.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic req, input logic [31:0] addr,
                       input logic [3:0] wen, input logic [31:0] wdata);
    case (which)
      2: begin bus2.dm_req = req; bus2.dm_addr = addr; bus2.dm_wen = wen; bus2.dm_wdata = wdata; end
      3: begin bus3.dm_req = req; bus3.dm_addr = addr; bus3.dm_wen = wen; bus3.dm_wdata = wdata; end
      default: begin bus0.dm_req = req; bus0.dm_addr = addr; bus0.dm_wen = wen; bus0.dm_wdata = wdata; end
    endcase
  endtask

  task automatic sample(input int which, output logic rv, output logic rdy,
                        output logic [31:0] rd, output logic er);
    case (which)
      2: begin rv = bus2.dm_rvalid; rdy = bus2.dm_ready; rd = bus2.dm_rdata; er = bus2.dm_err; end
      3: begin rv = bus3.dm_rvalid; rdy = bus3.dm_ready; rd = bus3.dm_rdata; er = bus3.dm_err; end
      default: begin rv = bus0.dm_rvalid; rdy = bus0.dm_ready; rd = bus0.dm_rdata; er = bus0.dm_err; end
    endcase
  endtask

  // One access from IDLE; measures edges from acceptance to the response.
  task automatic access(input int which, input vec_t v, input int exp_lat);
    logic rv, rdy, er;
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    drive(which, 1'b1, v.addr, v.wen, v.wdata);
    @(posedge clk); #1;
    drive(which, 1'b0, 32'd0, 4'd0, 32'd0);
    lat = 0;
    sample(which, rv, rdy, rd, er);
    while (!rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      sample(which, rv, rdy, rd, er);
    end
    check({v.name, "_latency"}, lat, exp_lat);
    check({v.name, "_rdata"}, rd, v.exp_rdata);
    check({v.name, "_err"}, er, v.exp_err);
    @(posedge clk); #1;
    sample(which, rv, rdy, rd, er);
    check({v.name, "_rvalid_drop"}, {rv, er, rdy}, 3'b001);
    check({v.name, "_rdata_idle"}, rd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic rv, rdy, er;
    logic [31:0] rd;
    int extra;

    vecs[0]  = '{32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0, "wr_full_10"};
    vecs[1]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 32'h1122_3344, 1'b0, "rd_10"};
    vecs[2]  = '{32'h0000_0011, 4'h2, 32'h0000_AB00, 32'h0000_0000, 1'b0, "wr_lane1"};
    vecs[3]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 32'h1122_AB44, 1'b0, "rd_lane1"};
    vecs[4]  = '{32'h0000_0000, 4'hF, 32'h5566_7788, 32'h0000_0000, 1'b0, "wr_word0"};
    vecs[5]  = '{32'h0000_0400, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, "wr_oor"};
    vecs[6]  = '{32'h0000_0000, 4'h0, 32'h0000_0000, 32'h5566_7788, 1'b0, "rd_word0"};
    vecs[7]  = '{32'h0000_0401, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, "rd_oor"};
    vecs[8]  = '{32'h0000_03FC, 4'hF, 32'h0102_0304, 32'h0000_0000, 1'b0, "wr_top"};
    vecs[9]  = '{32'h0000_03FF, 4'h9, 32'hAA00_00BB, 32'h0000_0000, 1'b0, "wr_top_lanes03"};
    vecs[10] = '{32'h0000_03FD, 4'h0, 32'h0000_0000, 32'hAA02_03BB, 1'b0, "rd_top"};
    vecs[11] = '{32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, "wr_oor_high"};
    vecs[12] = '{32'h0000_03FC, 4'h0, 32'h0000_0000, 32'hAA02_03BB, 1'b0, "rd_top_again"};

    rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    drive(0, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(2, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(3, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 4; w++) begin
      if (w != 1) begin
        sample(w, rv, rdy, rd, er);
        check($sformatf("reset_ctrl_dut%0d", w), {rv, er, rdy}, 3'b001);
        check($sformatf("reset_rdata_dut%0d", w), rd, 32'd0);
      end
    end
    @(negedge clk);
    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    for (int i = 0; i < 13; i++) access(0, vecs[i], 0);

    // Back-to-back: read presented while the write response is on the bus.
    @(negedge clk);
    drive(0, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check("b2b_wr_rvalid", bus0.dm_rvalid, 1'b1);
    check("b2b_wr_ready", bus0.dm_ready, 1'b1);
    drive(0, 1'b1, 32'h0000_0020, 4'h0, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 4'd0, 32'd0);
    check("b2b_rd_rvalid", bus0.dm_rvalid, 1'b1);
    check("b2b_rd_rdata", bus0.dm_rdata, 32'hCAFE_F00D);
    check("b2b_rd_err", bus0.dm_err, 1'b0);
    @(posedge clk); #1;
    check("b2b_idle_rvalid", bus0.dm_rvalid, 1'b0);

    // Three wait states with the request held high through the wait.
    access(3, '{32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0, 1'b0, "w3_wr"}, 3);
    @(negedge clk);
    drive(3, 1'b1, 32'h0000_0010, 4'h0, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w3_wait%0d_ready", k), bus3.dm_ready, 1'b0);
      check($sformatf("w3_wait%0d_rvalid", k), bus3.dm_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    check("w3_rd_rvalid", bus3.dm_rvalid, 1'b1);
    check("w3_rd_ready", bus3.dm_ready, 1'b1);
    check("w3_rd_rdata", bus3.dm_rdata, 32'h1234_5678);
    drive(3, 1'b0, 32'd0, 4'd0, 32'd0);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus3.dm_rvalid) extra++;
    end
    check("w3_single_accept", extra, 0);

    // Reset during the wait of a write drops it.
    access(2, '{32'h0000_0030, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, "w2_wr_old"}, 2);
    @(negedge clk);
    drive(2, 1'b1, 32'h0000_0030, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(2, 1'b0, 32'd0, 4'd0, 32'd0);
    check("w2_in_wait_ready", bus2.dm_ready, 1'b0);
    rst2 = 1'b0;
    #1;
    check("w2_async_reset_ready", bus2.dm_ready, 1'b1);
    check("w2_async_reset_rvalid", bus2.dm_rvalid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus2.dm_rvalid) extra++;
    end
    check("w2_no_resp_after_reset", extra, 0);
    access(2, '{32'h0000_0030, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "w2_rd_kept"}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
